// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: freeze/flush control for the 5-stage core with memory-wait watchdog.
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             pipe_freeze,
    output logic             mem_err,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX = '1;

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;

    logic memstall;
    logic sel_err;
    logic sel_mem;
    logic sel_br;
    logic sel_hz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nxt  = MEM_WAIT;
                    to_cnt_nxt = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = RUN;
                end else begin
                    if (to_cnt == TO_LIM)
                        state_nxt = ERR;
                    if (to_cnt != TO_MAX)
                        to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    // Stall sources are made mutually exclusive so the decoder is one-hot.
    assign memstall = ((state == RUN) && mem_req && !mem_ready)
                   || ((state == MEM_WAIT) && !mem_ready);
    assign sel_err  = !rst && (state == ERR);
    assign sel_mem  = !rst && memstall;
    assign sel_br   = !rst && !sel_err && !memstall && branch_taken;
    assign sel_hz   = !rst && !sel_err && !memstall && !branch_taken
                   && hazard;

    always_comb begin
        pc_freeze   = 1'b0;
        if_freeze   = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        pipe_freeze = 1'b0;
        mem_err     = 1'b0;
        unique case (1'b1)
            sel_err: begin
                mem_err     = 1'b1;
                pc_freeze   = 1'b1;
                if_freeze   = 1'b1;
                pipe_freeze = 1'b1;
            end
            sel_mem: begin
                pc_freeze   = 1'b1;
                if_freeze   = 1'b1;
                pipe_freeze = 1'b1;
            end
            sel_br: begin
                if_flush = 1'b1;
                id_flush = 1'b1;
            end
            sel_hz: begin
                pc_freeze = 1'b1;
                if_freeze = 1'b1;
                id_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = rst ? 2'd0 : state;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_freeze && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (if_flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = rst ? '0 : stall_q;
    assign flush_cnt = rst ? '0 : flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Perf counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard = 1'b0;
    logic branch_taken = 1'b0;
    logic mem_req = 1'b0;
    logic mem_ready = 1'b0;
    logic pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze, mem_err;
    logic [1:0] state_dbg;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // obs = {pc_frz, if_frz, if_fl, id_fl, pipe_frz, mem_err, state[1:0]}
    logic [7:0] obs;
    assign obs = {pc_freeze, if_freeze, if_flush, id_flush,
                  pipe_freeze, mem_err, state_dbg};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .TO_W(8),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hazard(hazard),
        .branch_taken(branch_taken),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .pc_freeze(pc_freeze),
        .if_freeze(if_freeze),
        .if_flush(if_flush),
        .id_flush(id_flush),
        .pipe_freeze(pipe_freeze),
        .mem_err(mem_err),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
`endif
        .state_dbg(state_dbg)
    );

    // v = {rst, hazard, branch_taken, mem_req, mem_ready}
    task automatic drive(input logic [4:0] v);
        @(negedge clk);
        {rst, hazard, branch_taken, mem_req, mem_ready} = v;
        #2;
    endtask

    task automatic test_reset;
        logic [4:0] stim [3] = '{5'b11111, 5'b11111, 5'b00000};
        logic [7:0] exp  [3] = '{8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_hazard;
        logic [4:0] stim [2] = '{5'b01000, 5'b00000};
        logic [7:0] exp  [2] = '{8'b11010000, 8'b00000000};
        for (int i = 0; i < 2; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL hazard[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_branch;
        logic [4:0] stim [3] = '{5'b01100, 5'b00100, 5'b00000};
        logic [7:0] exp  [3] = '{8'b00110000, 8'b00110000, 8'b00000000};
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL branch[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_mem_wait;
        logic [4:0] stim [5] = '{5'b00110, 5'b00110, 5'b00110,
                                 5'b00111, 5'b00000};
        logic [7:0] exp  [5] = '{8'b11001000, 8'b11001001, 8'b11001001,
                                 8'b00110001, 8'b00000000};
        for (int i = 0; i < 5; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_zero_wait;
        logic [4:0] stim [3] = '{5'b00011, 5'b00001, 5'b00000};
        logic [7:0] exp  [3] = '{8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL zero_wait[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_timeout_edge;
        logic [4:0] stim [6] = '{5'b00010, 5'b00010, 5'b00010,
                                 5'b00010, 5'b00011, 5'b00000};
        logic [7:0] exp  [6] = '{8'b11001000, 8'b11001001, 8'b11001001,
                                 8'b11001001, 8'b00000001, 8'b00000000};
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL to_edge[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_timeout;
        logic [4:0] stim [10] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010,
                                  5'b00010, 5'b00010, 5'b00011, 5'b01111,
                                  5'b10000, 5'b00000};
        logic [7:0] exp  [10] = '{8'b11001000, 8'b11001001, 8'b11001001,
                                  8'b11001001, 8'b11001001, 8'b11001110,
                                  8'b11001110, 8'b11001110, 8'b00000000,
                                  8'b00000000};
        for (int i = 0; i < 10; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_rst_midwait;
        logic [4:0] stim [4] = '{5'b00010, 5'b00010, 5'b10010, 5'b00000};
        logic [7:0] exp  [4] = '{8'b11001000, 8'b11001001, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL rst_mid[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf;
        logic [4:0] stim [7] = '{5'b10000, 5'b00010, 5'b00010, 5'b00010,
                                 5'b00011, 5'b01000, 5'b00000};
        for (int i = 0; i < 7; i++)
            drive(stim[i]);
        n_cmp++;
        if (stall_cnt !== 32'd4) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d want 4", stall_cnt);
        end
        n_cmp++;
        if (flush_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL flush_cnt0: got %0d want 0", flush_cnt);
        end
        drive(5'b00100);
        drive(5'b00000);
        n_cmp++;
        if (flush_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL flush_cnt1: got %0d want 1", flush_cnt);
        end
        n_cmp++;
        if (stall_cnt !== 32'd4) begin
            n_bad++;
            $display("FAIL stall_cnt_hold: got %0d want 4", stall_cnt);
        end
        drive(5'b10000);
        n_cmp++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL cnt_rst: got %0d/%0d want 0/0",
                     stall_cnt, flush_cnt);
        end
        drive(5'b00000);
    endtask
`endif

    initial begin
        test_reset();
        test_hazard();
        test_branch();
        test_mem_wait();
        test_zero_wait();
        test_timeout_edge();
        test_timeout();
        test_rst_midwait();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
